// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and types for the register file writeback arbiter.
//   DATA_W / ADDR_W : register data / address widths
//   NUM_REGS        : architectural register count (pending scoreboard width)
//   R0              : hardwired-zero register address; writes to it are discarded
package writeback_arbiter_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] R0 = '0;

  // One queued multdiv result
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    reg_onehot    = '0;
    reg_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// Multdiv result handshake into the writeback arbiter.
//   md_valid/md_reg/md_data : result offered by the multdiv unit
//   md_ready                : arbiter can take the result this cycle
// master = multdiv unit side, slave = arbiter side.
interface writeback_arbiter_if;
  import writeback_arbiter_pkg::*;
  logic              md_valid;
  logic [ADDR_W-1:0] md_reg;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;

  modport master (output md_valid, md_reg, md_data, input  md_ready);
  modport slave  (input  md_valid, md_reg, md_data, output md_ready);
endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small FIFO buffering multdiv results until the write port is free.
//   clk, rst              : clock, synchronous active-high reset (empties queue)
//   i_push, i_push_data   : enqueue (ignored when full)
//   i_pop                 : dequeue head (ignored when empty)
//   o_head                : current head entry (valid when !o_empty)
//   o_full, o_empty       : occupancy flags
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop  & ~o_empty;
  assign o_head  = r_mem[r_rd];

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Sole driver of the register file write port. Merges the never-stalled
// pipeline writeback with buffered multdiv results and tracks registers
// still waiting on a multdiv result.
//   clock, ctrl_reset       : clock, synchronous active-high reset
//   pipe_wr_en/reg/data     : pipeline writeback (highest priority)
//   md (slave)              : multdiv result valid/ready handshake
//   md_issue, md_issue_reg  : multdiv op issued; marks destination pending
//   pending                 : per-register "awaiting multdiv result"
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered write port
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clock,
  input  logic                ctrl_reset,
  input  logic                pipe_wr_en,
  input  logic [ADDR_W-1:0]   pipe_wr_reg,
  input  logic [DATA_W-1:0]   pipe_wr_data,
  writeback_arbiter_if.slave  md,
  input  logic                md_issue,
  input  logic [ADDR_W-1:0]   md_issue_reg,
  output logic [NUM_REGS-1:0] pending,
  output logic                ctrl_writeEnable,
  output logic [ADDR_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0]   data_writeReg
);
  localparam logic [NUM_REGS-1:0] R0_MASK = NUM_REGS'(1);

  wb_entry_t           w_head, w_md_ent, w_sel;
  logic                w_full, w_empty;
  logic                w_md_live, w_pipe_sel, w_pop, w_bypass, w_push;
  logic                w_we_nxt;
  logic [NUM_REGS-1:0] w_set, w_clr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_reg;
  logic [DATA_W-1:0]   r_data;
  logic [NUM_REGS-1:0] r_pend;

  // Ready ignores a same-cycle pop so the accept path never depends on selection
  assign md.md_ready = ~w_full & ~ctrl_reset;
  assign w_md_ent    = '{addr: md.md_reg, data: md.md_data};
  // Results for r0 are accepted but discarded
  assign w_md_live   = md.md_valid & md.md_ready & (md.md_reg != R0);
  assign w_pipe_sel  = pipe_wr_en & (pipe_wr_reg != R0);
  assign w_pop       = ~w_pipe_sel & ~w_empty;
  assign w_bypass    = ~w_pipe_sel & w_empty & w_md_live;
  assign w_push      = w_md_live & ~w_bypass;

  wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_entry_t))) u_fifo (
    .clk         (clock),
    .rst         (ctrl_reset),
    .i_push      (w_push),
    .i_push_data (w_md_ent),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_sel    = '{addr: r_reg, data: r_data};
    w_we_nxt = 1'b0;
    w_clr    = '0;
    if (w_pipe_sel) begin
      w_sel    = '{addr: pipe_wr_reg, data: pipe_wr_data};
      w_we_nxt = 1'b1;
    end else if (w_pop) begin
      w_sel    = w_head;
      w_we_nxt = 1'b1;
      w_clr    = reg_onehot(w_head.addr);
    end else if (w_bypass) begin
      w_sel    = w_md_ent;
      w_we_nxt = 1'b1;
      w_clr    = reg_onehot(w_md_ent.addr);
    end
  end

  assign w_set = (md_issue && md_issue_reg != R0) ? reg_onehot(md_issue_reg) : '0;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_we   <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
      r_pend <= '0;
    end else begin
      r_we   <= w_we_nxt;
      r_reg  <= w_sel.addr;
      r_data <= w_sel.data;
      // Set after clear: a re-issue to the same register keeps it pending
      r_pend <= ((r_pend & ~w_clr) | w_set) & ~R0_MASK;
    end
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_reg;
  assign data_writeReg    = r_data;
  assign pending          = r_pend;
endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;
  localparam int DEPTH = 2;

  logic                clock = 1'b0;
  logic                ctrl_reset;
  logic                pipe_wr_en;
  logic [ADDR_W-1:0]   pipe_wr_reg;
  logic [DATA_W-1:0]   pipe_wr_data;
  logic                md_issue;
  logic [ADDR_W-1:0]   md_issue_reg;
  logic [NUM_REGS-1:0] pending;
  logic                ctrl_writeEnable;
  logic [ADDR_W-1:0]   ctrl_writeReg;
  logic [DATA_W-1:0]   data_writeReg;

  writeback_arbiter_if md_if();

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_reg(pipe_wr_reg), .pipe_wr_data(pipe_wr_data),
    .md(md_if.slave), .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .pending(pending), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdv,
                       input logic iss, input logic [4:0] ir);
    ctrl_reset = rst; pipe_wr_en = pe; pipe_wr_reg = pr; pipe_wr_data = pd;
    md_if.md_valid = mv; md_if.md_reg = mr; md_if.md_data = mdv;
    md_issue = iss; md_issue_reg = ir;
  endtask

  // ---------------- table vectors (hand-derived expectations) ----------------
  typedef struct {
    logic pe; logic [4:0] pr; logic [31:0] pd;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic iss; logic [4:0] ir;
    logic rdy; logic we; logic [4:0] wr; logic [31:0] wd; logic [31:0] pend;
  } vec_t;
  vec_t vt[8];

  // ---------------- scoreboard model ----------------
  typedef struct { logic we; logic [4:0] wr; logic [31:0] wd; logic [31:0] pend; } exp_t;
  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  exp_t exp_q[$];
  ent_t mq[$];
  logic        m_we = 0;
  logic [4:0]  m_wr = 0;
  logic [31:0] m_wd = 0;
  logic [31:0] m_pend = 0;

  task automatic cycle(input logic rst, input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] mdv,
                       input logic iss, input logic [4:0] ir, output logic acc);
    logic e_rdy, live, byp;
    logic [31:0] clr;
    ent_t e;
    exp_t x;
    drive(rst, pe, pr, pd, mv, mr, mdv, iss, ir);
    #1;
    e_rdy = !rst && (mq.size() < DEPTH);
    chk("md_ready", 64'(md_if.md_ready), 64'(e_rdy));
    acc = mv & e_rdy;
    if (rst) begin
      m_we = 0; m_wr = 0; m_wd = 0; m_pend = 0; mq.delete();
    end else begin
      live = acc && (mr != 0);
      byp = 0; clr = 0;
      if (pe && pr != 0) begin
        m_we = 1; m_wr = pr; m_wd = pd;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1; m_wr = e.r; m_wd = e.d; clr = 32'(1) << e.r;
      end else if (live) begin
        byp = 1; m_we = 1; m_wr = mr; m_wd = mdv; clr = 32'(1) << mr;
      end else m_we = 0;
      if (live && !byp) mq.push_back('{r: mr, d: mdv});
      m_pend = (m_pend & ~clr) | ((iss && ir != 0) ? (32'(1) << ir) : 32'd0);
    end
    exp_q.push_back('{we: m_we, wr: m_wr, wd: m_wd, pend: m_pend});
    @(posedge clock); #1;
    x = exp_q.pop_front();
    chk("sb_we",   64'(ctrl_writeEnable), 64'(x.we));
    chk("sb_reg",  64'(ctrl_writeReg),    64'(x.wr));
    chk("sb_data", 64'(data_writeReg),    64'(x.wd));
    chk("sb_pend", 64'(pending),          64'(x.pend));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int r, naccept;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("rst_ready", 64'(md_if.md_ready), 64'd0);
    @(posedge clock); #1;
    chk("rst_we",   64'(ctrl_writeEnable), 64'd0);
    chk("rst_reg",  64'(ctrl_writeReg),    64'd0);
    chk("rst_data", 64'(data_writeReg),    64'd0);
    chk("rst_pend", 64'(pending),          64'd0);

    //        pe  pr   pd            mv  mr   md     iss ir   rdy we wr   wd            pend
    vt[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0,     0, 5'd0, 1, 1, 5'd5, 32'hDEADBEEF, 32'h0};
    vt[1] = '{0, 5'd0, 0,            0, 5'd0, 0,     1, 5'd7, 1, 0, 5'd5, 32'hDEADBEEF, 32'h80};
    vt[2] = '{0, 5'd0, 0,            1, 5'd7, 42,    0, 5'd0, 1, 1, 5'd7, 32'd42,       32'h0};
    vt[3] = '{1, 5'd0, 32'h1234,     1, 5'd0, 99,    0, 5'd0, 1, 0, 5'd7, 32'd42,       32'h0};
    vt[4] = '{0, 5'd0, 0,            0, 5'd0, 0,     0, 5'd0, 1, 0, 5'd7, 32'd42,       32'h0};
    vt[5] = '{0, 5'd0, 0,            0, 5'd0, 0,     1, 5'd0, 1, 0, 5'd7, 32'd42,       32'h0};
    vt[6] = '{1, 5'd3, 32'h33,       1, 5'd9, 32'h99, 1, 5'd9, 1, 1, 5'd3, 32'h33,      32'h200};
    vt[7] = '{0, 5'd0, 0,            0, 5'd0, 0,     0, 5'd0, 1, 1, 5'd9, 32'h99,       32'h0};

    for (int i = 0; i < 8; i++) begin
      drive(0, vt[i].pe, vt[i].pr, vt[i].pd, vt[i].mv, vt[i].mr, vt[i].md, vt[i].iss, vt[i].ir);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(md_if.md_ready), 64'(vt[i].rdy));
      @(posedge clock); #1;
      chk($sformatf("v%0d_we", i),   64'(ctrl_writeEnable), 64'(vt[i].we));
      chk($sformatf("v%0d_reg", i),  64'(ctrl_writeReg),    64'(vt[i].wr));
      chk($sformatf("v%0d_data", i), 64'(data_writeReg),    64'(vt[i].wd));
      chk($sformatf("v%0d_pend", i), 64'(pending),          64'(vt[i].pend));
    end

    // Re-sync model and DUT through reset, then check nothing is written after it
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Pipeline busy while multdiv offers 9,10,11: queue fills, then drains in order
    r = 9; naccept = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, i < 4, 5'd3, 32'(i), r <= 11, 5'(r), 32'(100 + r), 0, 0, acc);
      if (acc) begin
        r++;
        if (i < 4) naccept++;
      end
    end
    chk("accepts_while_pipe_busy", 64'(naccept), 64'd2);
    chk("all_md_accepted", 64'(r), 64'd12);

    // Re-issue to a register whose queued result leaves the same cycle: stays pending
    cycle(0, 1, 5'd3, 32'h1, 0, 0, 0, 1, 5'd12, acc);
    cycle(0, 1, 5'd3, 32'h2, 1, 5'd12, 32'h1212, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 5'd12, acc);
    chk("pend12_set_wins", 64'(pending[12]), 64'd1);
    chk("pend12_write_reg", 64'(ctrl_writeReg), 64'd12);

    // Reset with two queued results: both lost, nothing written afterwards
    cycle(0, 1, 5'd4, 32'h4, 1, 5'd20, 32'h20, 1, 5'd20, acc);
    cycle(0, 1, 5'd4, 32'h5, 1, 5'd21, 32'h21, 1, 5'd21, acc);
    cycle(1, 0, 0, 0, 1, 5'd22, 32'h22, 0, 0, acc);
    chk("rst_mid_pend", 64'(pending), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("rst_mid_no_write", 64'(ctrl_writeEnable), 64'd0);

    // Random mix against the model
    for (int i = 0; i < 200; i++)
      cycle(0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
